vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator for the VGA output path. Produces sync,

---
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with frame-aligned start/stop and prefetch request
module vga_timing_gen #(
    parameter int H_ACT    = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACT    = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PREFETCH = 2,
    parameter int COORD_W  = 16
) (
    input  logic                      clk_25M,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic                      i_stop,
    output logic                      VGA_HS,
    output logic                      VGA_VS,
    output logic                      VGA_BLANK_N,
    output logic                      VGA_SYNC_N,
    output logic                      de,
    output logic                      o_req,
    output logic                      line,
    output logic                      o_frame_start,
    output logic                      o_running,
    output logic signed [COORD_W-1:0] sx,
    output logic signed [COORD_W-1:0] sy
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;

    localparam logic signed [COORD_W-1:0] ZERO     = '0;
    localparam logic signed [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic signed [COORD_W-1:0] SX_MIN   = COORD_W'(-H_BLANK);
    localparam logic signed [COORD_W-1:0] SX_MAX   = COORD_W'(H_ACT - 1);
    localparam logic signed [COORD_W-1:0] SY_MIN   = COORD_W'(-V_BLANK);
    localparam logic signed [COORD_W-1:0] SY_MAX   = COORD_W'(V_ACT - 1);
    localparam logic signed [COORD_W-1:0] HS_BEG   = COORD_W'(H_FRONT - H_BLANK);
    localparam logic signed [COORD_W-1:0] HS_END   = COORD_W'(H_FRONT + H_SYNC - H_BLANK);
    localparam logic signed [COORD_W-1:0] VS_BEG   = COORD_W'(V_FRONT - V_BLANK);
    localparam logic signed [COORD_W-1:0] VS_END   = COORD_W'(V_FRONT + V_SYNC - V_BLANK);
    localparam logic signed [COORD_W-1:0] REQ_LO   = COORD_W'(-PREFETCH);
    localparam logic signed [COORD_W-1:0] REQ_HI   = COORD_W'(H_ACT - PREFETCH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

    state_t                      r_state, w_state_nxt;
    logic signed [COORD_W-1:0]   r_sx, r_sy, w_sx_nxt, w_sy_nxt;
    logic                        r_hs, r_vs, r_de, r_req, r_line, r_fs, r_run;
    logic                        w_last, w_run_nxt;

    assign w_last = (r_sx == SX_MAX) && (r_sy == SY_MAX);

    // A start request in STOPPING cancels the pending stop, even on the last pixel
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (i_start && !i_stop) w_state_nxt = S_RUN;
            S_RUN:      if (i_stop) w_state_nxt = S_STOPPING;
            S_STOPPING: begin
                if (i_start && !i_stop) w_state_nxt = S_RUN;
                else if (w_last)        w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Counters stay parked in IDLE, so leaving IDLE presents the first pixel immediately
    always_comb begin
        w_sx_nxt = SX_MIN;
        w_sy_nxt = SY_MIN;
        if (r_state != S_IDLE) begin
            if (r_sx == SX_MAX) begin
                w_sx_nxt = SX_MIN;
                w_sy_nxt = (r_sy == SY_MAX) ? SY_MIN : r_sy + ONE;
            end else begin
                w_sx_nxt = r_sx + ONE;
                w_sy_nxt = r_sy;
            end
        end
    end

    assign w_run_nxt = (w_state_nxt != S_IDLE);

    always_ff @(posedge clk_25M) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sx    <= SX_MIN;
            r_sy    <= SY_MIN;
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_de    <= 1'b0;
            r_req   <= 1'b0;
            r_line  <= 1'b0;
            r_fs    <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sx    <= w_sx_nxt;
            r_sy    <= w_sy_nxt;
            r_hs    <= (w_run_nxt && w_sx_nxt >= HS_BEG && w_sx_nxt < HS_END) ? HS_POL : ~HS_POL;
            r_vs    <= (w_run_nxt && w_sy_nxt >= VS_BEG && w_sy_nxt < VS_END) ? VS_POL : ~VS_POL;
            r_de    <= w_run_nxt && (w_sx_nxt >= ZERO) && (w_sy_nxt >= ZERO);
            r_req   <= w_run_nxt && (w_sy_nxt >= ZERO) && (w_sx_nxt >= REQ_LO) && (w_sx_nxt < REQ_HI);
            r_line  <= w_run_nxt && (w_sy_nxt >= ZERO) && (w_sx_nxt == SX_MIN);
            r_fs    <= w_run_nxt && (w_sx_nxt == SX_MIN) && (w_sy_nxt == SY_MIN);
            r_run   <= w_run_nxt;
        end
    end

    assign VGA_HS        = r_hs;
    assign VGA_VS        = r_vs;
    assign de            = r_de;
    assign VGA_BLANK_N   = r_de;
    assign VGA_SYNC_N    = 1'b0;
    assign o_req         = r_req;
    assign line          = r_line;
    assign o_frame_start = r_fs;
    assign o_running     = r_run;
    assign sx            = r_sx;
    assign sy            = r_sy;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a frame-position model
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HSY = 2, HBK = 2;
    localparam int VA = 4, VF = 1, VSY = 1, VBK = 1;
    localparam int PF = 2;
    localparam int HBL = HF + HSY + HBK;
    localparam int VBL = VF + VSY + VBK;
    localparam int LINE_LEN = HA + HBL;
    localparam int FRAME_LEN = LINE_LEN * (VA + VBL);

    typedef struct packed {
        logic        hs, vs, bn, sn, de, req, ln, fs, run;
        logic [15:0] sx, sy;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0, i_start = 1'b0, i_stop = 1'b0;
    logic hs, vs, bn, sn, de, req, ln, fs, run;
    logic signed [15:0] sx, sy;

    obs_t exp_q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    int   m_state = 0;   // 0 idle, 1 run, 2 stopping
    int   m_pos = 0;     // linear pixel index within the frame

    vga_timing_gen #(
        .H_ACT(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBK),
        .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBK),
        .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(PF), .COORD_W(16)
    ) dut (
        .clk_25M(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bn), .VGA_SYNC_N(sn),
        .de(de), .o_req(req), .line(ln), .o_frame_start(fs), .o_running(run),
        .sx(sx), .sy(sy)
    );

    always #5 clk = ~clk;

    function automatic obs_t expect_of(input int st, input int pos);
        obs_t e;
        int   x, y;
        bit   r;
        r = (st != 0);
        x = pos % LINE_LEN - HBL;
        y = pos / LINE_LEN - VBL;
        e.hs  = !(r && x >= HF - HBL && x < HF + HSY - HBL);
        e.vs  = !(r && y >= VF - VBL && y < VF + VSY - VBL);
        e.de  = r && x >= 0 && y >= 0;
        e.bn  = e.de;
        e.sn  = 1'b0;
        e.req = r && y >= 0 && x >= -PF && x < HA - PF;
        e.ln  = r && y >= 0 && x == -HBL;
        e.fs  = r && pos == 0;
        e.run = r;
        e.sx  = 16'(x);
        e.sy  = 16'(y);
        return e;
    endfunction

    task automatic step(input bit r, input bit st, input bit sp);
        int  ns;
        bit  last;
        rst_n = r; i_start = st; i_stop = sp;
        if (!r) begin
            m_state = 0;
            m_pos   = 0;
        end else begin
            last = (m_pos == FRAME_LEN - 1);
            ns   = m_state;
            case (m_state)
                0: if (st && !sp) ns = 1;
                1: if (sp) ns = 2;
                default: if (st && !sp) ns = 1; else if (last) ns = 0;
            endcase
            m_pos   = (m_state == 0) ? 0 : (m_pos + 1) % FRAME_LEN;
            m_state = ns;
        end
        exp_q.push_back(expect_of(m_state, m_pos));
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int pos);
        for (int n = 0; n < 2 * FRAME_LEN && m_pos != pos; n++) step(1, 0, 0);
    endtask

    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{hs, vs, bn, sn, de, req, ln, fs, run, sx, sy};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs cycle %0d: actual=%h (sx=%0d sy=%0d) required=%h (sx=%0d sy=%0d)",
                             cyc, a, $signed(a.sx), $signed(a.sy), e, $signed(e.sx), $signed(e.sy));
                end
            end
        end
    end

    initial begin
        step(0, 0, 0);
        step(0, 0, 0);
        // start pulse and three full frames
        step(1, 1, 0);
        for (int i = 0; i < 3 * FRAME_LEN; i++) step(1, $urandom_range(0, 1), 0);
        // stop mid-frame at sy=1, frame must finish then idle
        run_to(4 * LINE_LEN + 3);
        step(1, 0, 1);
        for (int i = 0; i < FRAME_LEN + 20; i++) step(1, 0, 0);
        // stop cancelled by start during STOPPING
        step(1, 1, 0);
        run_to(30);
        step(1, 0, 1);
        run_to(50);
        step(1, 1, 0);
        for (int i = 0; i < 2 * FRAME_LEN; i++) step(1, 0, 0);
        step(0, 0, 0);
        // start and stop together in IDLE
        for (int i = 0; i < 5; i++) step(1, 1, 1);
        step(1, 0, 0);
        // reset mid-frame at sx=3, sy=2
        step(1, 1, 0);
        run_to(5 * LINE_LEN + 9);
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        // randomized control traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 500) != 0, ($urandom % 40) == 0, ($urandom % 60) == 0);
        step(1, 0, 0);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
